// File: rtl/proto_field_encoder_if.sv
// Handshake bundle for proto_field_encoder: field commands,
// payload byte stream and serialized byte output.
interface proto_field_encoder_if;
  logic        fld_valid;
  logic        fld_ready;
  logic [4:0]  fld_num;
  logic [2:0]  fld_wire_type;
  logic [63:0] fld_value;
  logic        fld_last;
  logic [7:0]  pay_data;
  logic        pay_valid;
  logic        pay_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        err;

  modport master (
    output fld_valid, fld_num, fld_wire_type,
    output fld_value, fld_last,
    output pay_data, pay_valid, out_ready,
    input  fld_ready, pay_ready,
    input  out_data, out_valid, out_last, err
  );

  modport slave (
    input  fld_valid, fld_num, fld_wire_type,
    input  fld_value, fld_last,
    input  pay_data, pay_valid, out_ready,
    output fld_ready, pay_ready,
    output out_data, out_valid, out_last, err
  );
endinterface

// File: rtl/proto_field_encoder.sv
// Streaming protobuf field serializer: varint key, then
// varint / fixed / length-delimited body, one byte per cycle.
module proto_field_encoder #(
  parameter int LEN_W = 16,
  parameter int VAL_W = 64
) (
  input  logic clk,
  input  logic rst,
  proto_field_encoder_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_KEY  = 3'd1;
  localparam logic [2:0] S_VAR  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_PAY  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [VAL_W-1:0] v_q, v_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [2:0]       wt_q, wt_d;
  logic             last_q, last_d;
  logic [7:0]       odata_q, odata_d;
  logic             ovalid_q, ovalid_d;
  logic             olast_q, olast_d;
  logic             err_q, err_d;

  logic             load;
  logic             fld_hs;
  logic             wt_ok;
  logic             cmd_bad;
  logic [2:0]       wt_in;
  logic [7:0]       key;
  logic [VAL_W-1:0] v_sh7;
  logic             v_more;

  // Output slot refills when empty or being drained this cycle
  assign load   = !ovalid_q || bus.out_ready;
  assign wt_in  = bus.fld_wire_type;
  assign key    = {bus.fld_num, wt_in};
  assign v_sh7  = v_q >> 7;
  assign v_more = |v_sh7;

  assign bus.fld_ready = (state_q == S_IDLE) && !ovalid_q;
  assign bus.pay_ready = (state_q == S_PAY) && load;
  assign fld_hs = bus.fld_valid && bus.fld_ready;

  assign wt_ok = (wt_in == 3'd0) || (wt_in == 3'd1) ||
                 (wt_in == 3'd2) || (wt_in == 3'd5);
  assign cmd_bad = (bus.fld_num == 5'd0) || !wt_ok ||
                   ((wt_in == 3'd2) &&
                    (|bus.fld_value[VAL_W-1:LEN_W]));

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    cnt_d    = cnt_q;
    wt_d     = wt_q;
    last_d   = last_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    olast_d  = olast_q;
    err_d    = 1'b0;
    if (load) begin
      ovalid_d = 1'b0;
      olast_d  = 1'b0;
    end
    unique case (state_q)
      S_IDLE: begin
        if (fld_hs) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            // Key byte is the whole key; fields >= 16 add 0x01
            odata_d  = key;
            ovalid_d = 1'b1;
            wt_d     = wt_in;
            last_d   = bus.fld_last;
            if (wt_in == 3'd2)
              v_d = VAL_W'(bus.fld_value[LEN_W-1:0]);
            else
              v_d = bus.fld_value;
            if (wt_in == 3'd1)
              cnt_d = LEN_W'(8);
            else if (wt_in == 3'd5)
              cnt_d = LEN_W'(4);
            else
              cnt_d = bus.fld_value[LEN_W-1:0];
            if (bus.fld_num[4])
              state_d = S_KEY;
            else
              state_d = wt_in[0] ? S_FIX : S_VAR;
          end
        end
      end
      S_KEY: begin
        if (load) begin
          odata_d  = 8'h01;
          ovalid_d = 1'b1;
          state_d  = wt_q[0] ? S_FIX : S_VAR;
        end
      end
      S_VAR: begin
        if (load) begin
          odata_d  = {v_more, v_q[6:0]};
          ovalid_d = 1'b1;
          v_d      = v_sh7;
          if (!v_more) begin
            if ((wt_q == 3'd2) && (cnt_q != '0)) begin
              state_d = S_PAY;
            end else begin
              state_d = S_IDLE;
              olast_d = last_q;
            end
          end
        end
      end
      S_FIX: begin
        if (load) begin
          odata_d  = v_q[7:0];
          ovalid_d = 1'b1;
          v_d      = v_q >> 8;
          cnt_d    = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_IDLE;
            olast_d = last_q;
          end
        end
      end
      S_PAY: begin
        if (load && bus.pay_valid) begin
          odata_d  = bus.pay_data;
          ovalid_d = 1'b1;
          cnt_d    = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_IDLE;
            olast_d = last_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      v_q      <= '0;
      cnt_q    <= '0;
      wt_q     <= '0;
      last_q   <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      cnt_q    <= cnt_d;
      wt_q     <= wt_d;
      last_q   <= last_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      err_q    <= err_d;
    end
  end

  assign bus.out_data  = odata_q;
  assign bus.out_valid = ovalid_q;
  assign bus.out_last  = olast_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_proto_field_encoder.sv
// Bench for proto_field_encoder: known vectors, stalls,
// rejects, resets and random fields against a wire-format model.
module tb_proto_field_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  proto_field_encoder_if bus();

  proto_field_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int nerr = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] obs_q[$];
  bit         obs_last_q[$];
  int pay_hs, stall_viol, extra, first_lat, span, err_seen;
  bit ready_after, timeout;

  // Reference: base-128 little-endian groups, MSB = more follows
  function automatic void push_varint(input logic [63:0] x);
    logic [63:0] r;
    r = x;
    do begin
      if (r >= 64'd128)
        exp_q.push_back(8'((r % 64'd128) + 64'd128));
      else
        exp_q.push_back(8'(r));
      r = r / 64'd128;
    end while (r != 64'd0);
  endfunction

  function automatic void build_exp(input int num, input int wt,
                                    input logic [63:0] val);
    exp_q.delete();
    push_varint(64'(num * 8 + wt));
    case (wt)
      0: push_varint(val);
      1: for (int i = 0; i < 8; i++)
           exp_q.push_back(8'(val >> (8 * i)));
      5: for (int i = 0; i < 4; i++)
           exp_q.push_back(8'(val >> (8 * i)));
      2: begin
        push_varint(val);
        for (int i = 0; i < int'(val); i++)
          exp_q.push_back(pay_q[i]);
      end
      default: ;
    endcase
  endfunction

  task automatic run_field(input int num, input int wt,
                           input logic [63:0] val, input bit last,
                           input bit stall, input bit pgap,
                           input int nexp);
    int pidx, hs_cyc, first_cyc, last_cyc;
    bit sent, prev_stall, prev_last;
    logic [7:0] prev_data;
    obs_q.delete();
    obs_last_q.delete();
    pay_hs = 0; stall_viol = 0; extra = 0; err_seen = 0;
    timeout = 1'b1; sent = 1'b0; prev_stall = 1'b0;
    prev_last = 1'b0; prev_data = 8'h00; pidx = 0;
    hs_cyc = 0; first_cyc = -1; last_cyc = 0;
    bus.fld_num = 5'(num);
    bus.fld_wire_type = 3'(wt);
    bus.fld_value = val;
    bus.fld_last = last;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      bus.fld_valid = !sent;
      bus.out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.pay_valid = (pidx < pay_q.size()) &&
                      (pgap ? ($urandom_range(0, 3) != 0) : 1'b1);
      bus.pay_data = (pidx < pay_q.size()) ? pay_q[pidx]
                                           : 8'($urandom);
      #1;
      if (prev_stall && (!bus.out_valid ||
          bus.out_data !== prev_data ||
          bus.out_last !== prev_last))
        stall_viol++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_last = bus.out_last;
      if (bus.err) err_seen++;
      if (!sent && bus.fld_ready) begin
        sent = 1'b1;
        hs_cyc = cyc;
      end
      if (bus.pay_valid && bus.pay_ready) begin
        pidx++;
        pay_hs++;
      end
      if (bus.out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (bus.out_ready) begin
          obs_q.push_back(bus.out_data);
          obs_last_q.push_back(bus.out_last);
          last_cyc = cyc;
        end
      end
      if (sent && obs_q.size() >= nexp) begin
        timeout = 1'b0;
        break;
      end
    end
    @(negedge clk);
    bus.fld_valid = 1'b0;
    bus.pay_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    ready_after = bus.fld_ready;
    for (int i = 0; i < 3; i++) begin
      if (bus.out_valid) extra++;
      if (bus.err) err_seen++;
      @(negedge clk);
      #1;
    end
    first_lat = first_cyc - hs_cyc;
    span = last_cyc - hs_cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.fld_valid = 1'b0; bus.fld_num = '0;
    bus.fld_wire_type = '0; bus.fld_value = '0;
    bus.fld_last = 1'b0; bus.pay_data = '0;
    bus.pay_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.pay_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    nvec++;
    if (bus.fld_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rst_fld_ready: got %b want 1", bus.fld_ready);
    end
    nvec++;
    if (bus.pay_ready !== 1'b0) begin
      nerr++;
      $display("FAIL rst_pay_ready: got %b want 0", bus.pay_ready);
    end
    nvec++;
    if ({bus.out_valid, bus.out_last, bus.err} !== 3'b000) begin
      nerr++;
      $display("FAIL rst_flags: got %b want 000",
               {bus.out_valid, bus.out_last, bus.err});
    end
    nvec++;
    if (bus.out_data !== 8'h00) begin
      nerr++;
      $display("FAIL rst_out_data: got %h want 00", bus.out_data);
    end
    bus.pay_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_known();
    int num, wt, phs;
    logic [63:0] val;
    bit last;
    for (int k = 0; k < 6; k++) begin
      pay_q = '{8'hAA, 8'h55};
      phs = 0; num = 1; wt = 0; val = 0; last = 1'b0;
      case (k)
        0: begin
          num = 1; wt = 0; val = 150; last = 1'b1;
          exp_q = '{8'h08, 8'h96, 8'h01};
        end
        1: begin
          num = 2; wt = 2; val = 7; last = 1'b1; phs = 7;
          pay_q = '{8'h74, 8'h65, 8'h73, 8'h74,
                    8'h69, 8'h6E, 8'h67};
          exp_q = '{8'h12, 8'h07, 8'h74, 8'h65, 8'h73,
                    8'h74, 8'h69, 8'h6E, 8'h67};
        end
        2: begin
          num = 2; wt = 2; val = 0; last = 1'b1;
          pay_q.delete();
          exp_q = '{8'h12, 8'h00};
        end
        3: begin
          num = 16; wt = 0; val = 1; last = 1'b0;
          exp_q = '{8'h80, 8'h01, 8'h01};
        end
        4: begin
          num = 5; wt = 5; val = 64'h12345678; last = 1'b1;
          exp_q = '{8'h2D, 8'h78, 8'h56, 8'h34, 8'h12};
        end
        default: begin
          num = 3; wt = 1; val = 64'h0102030405060708;
          last = 1'b0;
          exp_q = '{8'h19, 8'h08, 8'h07, 8'h06, 8'h05,
                    8'h04, 8'h03, 8'h02, 8'h01};
        end
      endcase
      run_field(num, wt, val, last, 1'b0, 1'b0, exp_q.size());
      nvec++;
      if (timeout !== 1'b0 || obs_q.size() != exp_q.size()) begin
        nerr++;
        $display("FAIL known%0d_count: got %0d bytes want %0d",
                 k, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        nvec++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i] ||
            obs_last_q[i] !== (last && i == exp_q.size() - 1)) begin
          nerr++;
          $display("FAIL known%0d_byte%0d: got %h want %h last %b",
                   k, i, (i < obs_q.size()) ? obs_q[i] : 8'hxx,
                   exp_q[i], last && i == exp_q.size() - 1);
        end
      end
      nvec++;
      if (span != exp_q.size() || first_lat != 1) begin
        nerr++;
        $display("FAIL known%0d_timing: got span %0d lat %0d want %0d 1",
                 k, span, first_lat, exp_q.size());
      end
      nvec++;
      if (pay_hs != phs) begin
        nerr++;
        $display("FAIL known%0d_pay_hs: got %0d want %0d",
                 k, pay_hs, phs);
      end
      nvec++;
      if (ready_after !== 1'b1 || extra != 0 || err_seen != 0) begin
        nerr++;
        $display("FAIL known%0d_done: got rdy %b extra %0d err %0d want 1 0 0",
                 k, ready_after, extra, err_seen);
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] val;
    val = 64'hFFFF_FFFF_FFFF_FFFF;
    pay_q = '{8'hC3};
    build_exp(1, 0, val);
    run_field(1, 0, val, 1'b1, 1'b1, 1'b1, exp_q.size());
    nvec++;
    if (timeout !== 1'b0 || obs_q.size() != exp_q.size()) begin
      nerr++;
      $display("FAIL stall_count: got %0d bytes want %0d",
               obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      nvec++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i] ||
          obs_last_q[i] !== (i == exp_q.size() - 1)) begin
        nerr++;
        $display("FAIL stall_byte%0d: got %h want %h",
                 i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
      end
    end
    nvec++;
    if (stall_viol != 0 || pay_hs != 0) begin
      nerr++;
      $display("FAIL stall_hold: got viol %0d pay %0d want 0 0",
               stall_viol, pay_hs);
    end
  endtask

  task automatic test_reject();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.fld_num = (k == 1) ? 5'd0 : 5'd4;
      bus.fld_wire_type = (k == 0) ? 3'd3 : ((k == 1) ? 3'd0 : 3'd2);
      bus.fld_value = (k == 2) ? 64'h10000 : 64'd5;
      bus.fld_last = 1'b1;
      bus.fld_valid = 1'b1;
      bus.out_ready = 1'b1;
      bus.pay_valid = 1'b0;
      #1;
      nvec++;
      if (bus.fld_ready !== 1'b1) begin
        nerr++;
        $display("FAIL rej%0d_ready: got %b want 1", k, bus.fld_ready);
      end
      @(negedge clk);
      bus.fld_valid = 1'b0;
      #1;
      nvec++;
      if ({bus.err, bus.out_valid, bus.fld_ready} !== 3'b101) begin
        nerr++;
        $display("FAIL rej%0d_pulse: got %b want 101", k,
                 {bus.err, bus.out_valid, bus.fld_ready});
      end
      @(negedge clk);
      #1;
      nvec++;
      if ({bus.err, bus.out_valid} !== 2'b00) begin
        nerr++;
        $display("FAIL rej%0d_after: got %b want 00", k,
                 {bus.err, bus.out_valid});
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.fld_num = 5'd4; bus.fld_wire_type = 3'd2;
    bus.fld_value = 64'd20; bus.fld_last = 1'b1;
    bus.fld_valid = 1'b1; bus.out_ready = 1'b1;
    bus.pay_valid = 1'b1; bus.pay_data = 8'h5A;
    @(negedge clk);
    bus.fld_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    nvec++;
    if ({bus.pay_ready, bus.out_valid} !== 2'b11) begin
      nerr++;
      $display("FAIL mid_payload: got %b want 11",
               {bus.pay_ready, bus.out_valid});
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    nvec++;
    if ({bus.out_valid, bus.pay_ready, bus.fld_ready,
         bus.out_last} !== 4'b0010) begin
      nerr++;
      $display("FAIL mid_rst: got %b want 0010",
               {bus.out_valid, bus.pay_ready, bus.fld_ready,
                bus.out_last});
    end
    rst = 1'b0;
    bus.pay_valid = 1'b0;
    pay_q = '{8'hAA};
    build_exp(1, 0, 64'd150);
    run_field(1, 0, 64'd150, 1'b1, 1'b0, 1'b0, exp_q.size());
    nvec++;
    if (timeout !== 1'b0 || obs_q != exp_q) begin
      nerr++;
      $display("FAIL mid_clean: got %0d bytes first %h want %0d %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx,
               exp_q.size(), exp_q[0]);
    end
  endtask

  task automatic test_random();
    int wts[4];
    int num, wt, len, phs;
    logic [63:0] val;
    bit last;
    wts = '{0, 1, 2, 5};
    for (int n = 0; n < 40; n++) begin
      num = $urandom_range(1, 31);
      wt = wts[$urandom_range(0, 3)];
      last = 1'($urandom_range(0, 1));
      pay_q.delete();
      if (wt == 2) begin
        len = $urandom_range(0, 12);
        val = 64'(len);
        phs = len;
        for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
      end else begin
        val = {$urandom, $urandom};
        val = val >> $urandom_range(0, 63);
        phs = 0;
        pay_q = '{8'($urandom), 8'($urandom)};
      end
      build_exp(num, wt, val);
      run_field(num, wt, val, last, 1'b1, 1'b1, exp_q.size());
      nvec++;
      if (timeout !== 1'b0 || obs_q.size() != exp_q.size()) begin
        nerr++;
        $display("FAIL rnd%0d_count: f%0d wt%0d got %0d want %0d",
                 n, num, wt, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        nvec++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i] ||
            obs_last_q[i] !== (last && i == exp_q.size() - 1)) begin
          nerr++;
          $display("FAIL rnd%0d_byte%0d: got %h want %h",
                   n, i, (i < obs_q.size()) ? obs_q[i] : 8'hxx,
                   exp_q[i]);
        end
      end
      nvec++;
      if (pay_hs != phs || stall_viol != 0 || first_lat != 1) begin
        nerr++;
        $display("FAIL rnd%0d_flow: got pay %0d viol %0d lat %0d want %0d 0 1",
                 n, pay_hs, stall_viol, first_lat, phs);
      end
      nvec++;
      if (ready_after !== 1'b1 || extra != 0 || err_seen != 0) begin
        nerr++;
        $display("FAIL rnd%0d_done: got rdy %b extra %0d err %0d want 1 0 0",
                 n, ready_after, extra, err_seen);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_stall();
    test_reject();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/proto_field_encoder.md
Name: proto_field_encoder

Overview:
Streaming protobuf serializer, the transmit-side counterpart of the field decoder.
- Accepts one field command per handshake: field number, wire type, value or length.
- Emits the wire-format byte stream: varint key, then varint / fixed / length-delimited body.
- For length-delimited fields, forwards payload bytes from a separate byte stream.
- Sits between the message-building logic and the byte-serial output channel.

Parameters:
LEN_W, 16, width of the length-delimited length; length is taken from fld_value[LEN_W-1:0].
VAL_W, 64, width of fld_value; fixed at 64 for fixed64 support.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fld_valid  in  1  field command valid
fld_ready  out  1  field command accepted when fld_valid&&fld_ready
fld_num  in  5  field number, 1..31
fld_wire_type  in  3  0=varint, 1=fixed64, 2=length-delimited, 5=fixed32
fld_value  in  64  varint value, fixed value, or payload length (wire type 2)
fld_last  in  1  field is the last of its message
pay_data  in  8  payload byte (wire type 2 only)
pay_valid  in  1  payload byte valid
pay_ready  out  1  payload byte consumed when pay_valid&&pay_ready
out_data  out  8  serialized byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts a byte when out_valid&&out_ready
out_last  out  1  final byte of a field issued with fld_last=1
err  out  1  one-cycle pulse: command rejected

Behaviour:
- Reset (sync, active high, overrides everything, including mid-field): state IDLE; fld_ready=1, pay_ready=0, out_valid=0, out_last=0, out_data=0, err=0; counters cleared. Partial field output is abandoned; no further bytes are emitted.
- States: IDLE, KEY, BODY_VARINT, BODY_FIXED, PAYLOAD.
- IDLE: fld_ready=1. On handshake, latch command. The first byte is presented with out_valid=1 on the next cycle.
- Rejection: fld_num==0, wire type in {3,4,6,7}, or (wire type 2 and fld_value[63:LEN_W]!=0) -> err=1 for one cycle, remain in IDLE, emit nothing.
- KEY: key = {fld_num, wire_type} (8 bits), encoded as a varint.
  - fld_num<16: one byte, key.
  - fld_num>=16: two bytes, {1,key[6:0]} then 8'h01.
  - Next state: BODY_VARINT for wire types 0 and 2; BODY_FIXED for 1 and 5.
- BODY_VARINT: shift register v.
  - Each byte = {(v>>7)!=0, v[6:0]}, then v>>=7.
  - Ends on the byte with MSB=0; value 0 emits a single 8'h00; max 10 bytes.
  - Wire type 2 encodes the length here, then goes to PAYLOAD, or straight to done when length=0.
- BODY_FIXED: little-endian; 4 bytes for wire type 5, 8 bytes for wire type 1.
- PAYLOAD: pay_ready = out_ready || !out_valid; each consumed payload byte becomes the next out_data. A down-counter from the length ends the field after the last byte.
- Output register: out_data, out_valid and out_last hold stable while out_valid&&!out_ready. A new byte loads only when the slot is empty or being accepted. Full throughput is 1 byte/cycle.
- out_last=1 only with the final byte of a field whose latched fld_last=1. That byte is the length byte if the length is 0.
- Done: after the final byte is accepted, return to IDLE, fld_ready=1 on the following cycle. No command overlap: a field occupies 1 + bytes emitted cycles minimum.
- pay_valid outside PAYLOAD is ignored: pay_ready=0, no bytes consumed.

Test Plan:
- Field 1, wt0, value 150, fld_last=1, out_ready=1 -> 0x08,0x96,0x01 on consecutive cycles; out_last only on 0x01; fld_ready high again after.
- Field 2, wt2, len 7, payload "testing" -> 0x12,0x07,74 65 73 74 69 6E 67; exactly 7 pay handshakes; len 0 -> 0x12,0x00 with out_last on 0x00.
- Field 16, wt0, value 1 -> 0x80,0x01,0x01; field 5, wt5, 0x12345678 -> 0x2D,0x78,0x56,0x34,0x12; wt1 value 0x0102030405060708 field 3 -> 0x19 then 08..01.
- Random out_ready toggling during a 10-byte varint (value 2^64-1) -> byte sequence and count unchanged: FF x9 then 0x01; out_data stable while stalled.
- wt3, or fld_num=0, or wt2 length 0x10000 -> err pulses 1 cycle, no out_valid, fld_ready stays 1.
- rst asserted mid-PAYLOAD -> next cycle out_valid=0, pay_ready=0, fld_ready=1; the following field encodes cleanly.
